// File: rtl/siso_branch_metric_gen.sv
// siso_branch_metric_gen: max-log-MAP gamma front end; define BM_SATURATE_EN to clamp metrics instead of wrapping
module siso_branch_metric_gen #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 18,
  parameter int MAX_BLK  = 6144,
  parameter int TAIL_LEN = 3,
  parameter int BLK_W    = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  apriori,
  input  logic                    valid_apriori,
  input  logic [BLK_W-1:0]        blklen,
  input  logic                    valid_blklen,
  output logic signed [OUT_W-1:0] branch1,
  output logic signed [OUT_W-1:0] branch2,
  output logic                    valid_out,
  output logic                    first_out,
  output logic                    last_out,
  output logic                    busy,
  output logic                    err
);
  localparam int EXT_W = IN_W + 2;
  localparam int W = OUT_W > EXT_W ? OUT_W : EXT_W;
  typedef enum logic [2:0] {IDLE, SYS, PAR, TSYS, TPAR} state_t;
  state_t r_state, w_next;
  logic [BLK_W-1:0] r_blklen, r_step, w_lim;
  logic signed [IN_W-1:0] r_sys, w_apr;
  logic signed [W-1:0] w_sys, w_aprx, w_par, w_sum1, w_sum2;
  logic w_blk_ok, w_sys_acc, w_par_acc, w_step_last, w_err_set;
`ifdef BM_SATURATE_EN
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  function automatic logic signed [OUT_W-1:0] reduce(input logic signed [W-1:0] v);
    return (v > MAX_V) ? MAX_V[OUT_W-1:0] : (v < MIN_V) ? MIN_V[OUT_W-1:0] : v[OUT_W-1:0];
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] reduce(input logic signed [W-1:0] v);
    return v[OUT_W-1:0];
  endfunction
`endif
  assign w_blk_ok    = valid_blklen && blklen != '0 && blklen <= BLK_W'(MAX_BLK);
  assign w_sys_acc   = valid_in && (r_state == SYS || r_state == TSYS);
  assign w_par_acc   = valid_in && (r_state == PAR || r_state == TPAR);
  assign w_lim       = r_state == PAR ? r_blklen : BLK_W'(TAIL_LEN);
  assign w_step_last = (r_step + BLK_W'(1)) == w_lim;
  assign w_err_set   = (valid_apriori && !w_par_acc) || (valid_blklen && (r_state != IDLE || !w_blk_ok));
  assign w_apr       = (r_state == PAR && valid_apriori) ? apriori : '0;
  assign w_sys       = {{(W-IN_W){r_sys[IN_W-1]}}, r_sys};
  assign w_aprx      = {{(W-IN_W){w_apr[IN_W-1]}}, w_apr};
  assign w_par       = {{(W-IN_W){in[IN_W-1]}}, in};
  assign w_sum1      = w_sys + w_aprx + w_par;
  assign w_sum2      = w_sys + w_aprx - w_par;
  assign busy        = r_state != IDLE;
  // next state: framing of data steps followed by tail steps
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_blk_ok) ? SYS :
             w_sys_acc ? (r_state == SYS ? PAR : TPAR) :
             w_par_acc ? (r_state == PAR ? (w_step_last ? TSYS : SYS) : (w_step_last ? IDLE : TSYS)) :
             r_state;
  end
  // state, counters, registered metrics and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_blklen  <= '0;
      r_step    <= '0;
      r_sys     <= '0;
      branch1   <= '0;
      branch2   <= '0;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      if (r_state == IDLE && w_blk_ok) begin
        r_blklen <= blklen;
        r_step   <= '0;
      end
      if (w_sys_acc) r_sys <= in;
      if (w_par_acc) begin
        r_step  <= w_step_last ? '0 : r_step + BLK_W'(1);
        branch1 <= reduce(w_sum1);
        branch2 <= reduce(w_sum2);
      end
      valid_out <= w_par_acc;
      first_out <= w_par_acc && r_state == PAR && r_step == '0;
      last_out  <= w_par_acc && r_state == TPAR && w_step_last;
      err       <= err | w_err_set;
    end
  end
endmodule
